// File: rtl/data_bus_responder.sv
// data_bus_responder
// Responder side of the CPU data-memory port. Converts ram_ce/we/sel requests
// into word accesses on a variable-latency req/ack backing port; partial-word
// stores become read-modify-write.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for ram_ce_i; busy follows ram_ce_i combinationally
// S_RD    | backing read outstanding (loads and partial stores)
// S_MERGE | one cycle to splice store lanes into the read word
// S_WR    | backing write outstanding
// S_DONE  | one-cycle completion; busy low so the pipeline advances
module data_bus_responder #(
   parameter int          ADDR_W   = 22,
   parameter int          TIMEOUT  = 1023,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_ce_i,
   input  logic              ram_we_i,
   input  logic [31:0]       ram_addr_i,
   input  logic [3:0]        ram_sel_i,
   input  logic [31:0]       ram_data_i,
   output logic [31:0]       ram_data_o,
   output logic              DataBus_busy,
   output logic              DataBus_done,
   output logic              bus_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD    = 3'd1;
   localparam logic [2:0] S_MERGE = 3'd2;
   localparam logic [2:0] S_WR    = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int               CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

   logic [2:0]        r_state;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [31:0]       r_data;
   logic [31:0]       r_rdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_ram_data;
   logic              r_done;
   logic              r_err;

   logic [31:0]       w_merged;
   logic              w_tmo;
   logic              w_unused_addr;

   // byte-address bits below the word and above the backing range are dropped
   assign w_unused_addr = ^{ram_addr_i[1:0], ram_addr_i[31:ADDR_W+2]};

   // counter has reached its limit; TIMEOUT of zero disables the abort path
   assign w_tmo = (TIMEOUT != 0) && (r_cnt == LP_TMO);

   // splice enabled store lanes over the word read back from memory
   always_comb begin
      w_merged = r_rdata;
      for (int i = 0; i < 4; i++) begin
         if (r_sel[i]) w_merged[8*i +: 8] = r_data[8*i +: 8];
      end
   end

   // sequencer: request latch, backing handshake, timeout and completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_sel       <= 4'h0;
         r_data      <= 32'h0;
         r_rdata     <= 32'h0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'h0;
         r_ram_data  <= 32'h0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ram_ce_i) begin
                  r_we       <= ram_we_i;
                  r_sel      <= ram_sel_i;
                  r_data     <= ram_data_i;
                  r_mem_addr <= ram_addr_i[ADDR_W+1:2];
                  r_cnt      <= '0;
                  r_mem_req  <= 1'b1;
                  if (ram_we_i && (ram_sel_i == 4'hF)) begin
                     r_mem_we    <= 1'b1;
                     r_mem_wdata <= ram_data_i;
                     r_state     <= S_WR;
                  end else begin
                     r_mem_we <= 1'b0;
                     r_state  <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (mem_ack_i) begin
                  r_rdata   <= mem_rdata_i;
                  r_mem_req <= 1'b0;
                  if (r_we) begin
                     r_state <= S_MERGE;
                  end else begin
                     r_ram_data <= mem_rdata_i;
                     r_done     <= 1'b1;
                     r_state    <= S_DONE;
                  end
               end else if (w_tmo) begin
                  // an aborted RMW never reaches the write phase
                  r_mem_req <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_state   <= S_DONE;
                  if (!r_we) r_ram_data <= ERR_DATA;
               end else if (r_cnt != LP_TMO) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_MERGE: begin
               r_mem_wdata <= w_merged;
               r_mem_we    <= 1'b1;
               r_mem_req   <= 1'b1;
               r_cnt       <= '0;
               r_state     <= S_WR;
            end
            S_WR: begin
               if (mem_ack_i || w_tmo) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= !mem_ack_i;
                  r_state   <= S_DONE;
               end else if (r_cnt != LP_TMO) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign DataBus_busy = ((r_state == S_IDLE) && ram_ce_i) || (r_state == S_RD) ||
                         (r_state == S_MERGE) || (r_state == S_WR);
   assign DataBus_done = r_done;
   assign bus_err_o    = r_err;
   assign ram_data_o   = r_ram_data;
   assign mem_req_o    = r_mem_req;
   assign mem_we_o     = r_mem_we;
   assign mem_addr_o   = r_mem_addr;
   assign mem_wdata_o  = r_mem_wdata;

endmodule
